// File: rtl/sm4_pkg.sv
// sm4_pkg: shared definitions for the SM4 key-expansion engine.
//   FK0..FK3      : system parameters XORed into the master key.
//   SBOX          : 256-entry SM4 substitution table.
//   ck_word(i)    : round constant CK_i, byte j = (4i+j)*7 mod 256 (byte 0 is MSB).
//   tau()         : byte-wise S-box substitution of a 32-bit word.
//   l_prime()     : key-schedule linear transform B ^ (B<<<13) ^ (B<<<23).
//   sm4_state_e   : expansion FSM states.
package sm4_pkg;

   localparam logic [31:0] FK0 = 32'ha3b1bac6;
   localparam logic [31:0] FK1 = 32'h56aa3350;
   localparam logic [31:0] FK2 = 32'h677d9197;
   localparam logic [31:0] FK3 = 32'hb27022dc;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sm4_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   function automatic logic [31:0] ck_word(input logic [4:0] i);
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         w[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
      end
      return w;
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
   endfunction

   function automatic logic [31:0] l_prime(input logic [31:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

endpackage

// File: rtl/sm4_keyexp_round.sv
// sm4_keyexp_round: one combinational SM4 key-expansion round.
//   k_in  : {K_i, K_i+1, K_i+2, K_i+3}, K_i in [127:96]
//   ck    : round constant CK_i
//   k_out : {K_i+1, K_i+2, K_i+3, K_i+4}
//   rk    : round key rk_i (= K_i+4)
module sm4_keyexp_round
   import sm4_pkg::*;
(
   input  logic [127:0] k_in,
   input  logic [31:0]  ck,
   output logic [127:0] k_out,
   output logic [31:0]  rk
);

   logic [31:0] k0, k1, k2, k3;

   assign {k0, k1, k2, k3} = k_in;
   assign rk    = k0 ^ l_prime(tau(k1 ^ k2 ^ k3 ^ ck));
   assign k_out = {k1, k2, k3, rk};

endmodule

// File: rtl/sm4_key_schedule_mr.sv
// sm4_key_schedule_mr: multi-round SM4 key expansion engine with slotted
// round-key storage and a registered read port.
//   clk, rst            : clock, synchronous active-high reset
//   key_valid/key_ready : master-key handshake (key_ready high while idle)
//   key_in, key_slot    : master key MK0..MK3 (MK0 in [127:96]) and target slot
//   abort               : cancel the expansion in progress
//   busy, done          : expansion running / one-cycle completion pulse
//   slot_valid          : per-slot "complete key stored" flags
//   rd_en, rd_slot, rd_idx, rd_dec : read request; rd_dec reverses the order
//   rd_data, rd_hit     : registered round key and slot-valid at request time
// Optional build macro SM4_KEY_ZEROIZE_EN: when defined, reset clears all key
// storage and abort clears the aborted slot; otherwise storage is never
// cleared and only the flags are reset.
module sm4_key_schedule_mr
   import sm4_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int NUM_SLOTS        = 2,
   parameter int SLOT_W           = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_valid,
   output logic                 key_ready,
   input  logic [127:0]         key_in,
   input  logic [SLOT_W-1:0]    key_slot,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_SLOTS-1:0] slot_valid,
   input  logic                 rd_en,
   input  logic [SLOT_W-1:0]    rd_slot,
   input  logic [4:0]           rd_idx,
   input  logic                 rd_dec,
   output logic [31:0]          rd_data,
   output logic                 rd_hit
);

   localparam int         R        = ROUNDS_PER_CYCLE;
   localparam logic [4:0] CNT_STEP = 5'(R);
   localparam logic [4:0] CNT_LAST = 5'(32 - R);

   if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end
   if (NUM_SLOTS < 1 || NUM_SLOTS > 4) begin : g_bad_slots
      $error("NUM_SLOTS must be in 1..4");
   end

   sm4_state_e            state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [127:0]          k_q, k_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic                  done_q, done_d;
   logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic                  rd_hit_q, rd_hit_d;

   logic [31:0]           store_mem [NUM_SLOTS][32];

   logic [127:0]          k_chain [R+1];
   logic [31:0]           rk_w [R];
   logic [4:0]            wr_idx [R];
   logic [4:0]            rd_word;
   logic                  run;

   assign run        = (state_q == ST_RUN);
   assign key_ready  = (state_q == ST_IDLE);
   assign busy       = run;
   assign done       = done_q;
   assign slot_valid = slot_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_hit     = rd_hit_q;

   // Decryption order is a read-time index reversal, so one stored set serves both.
   assign rd_word = rd_dec ? (5'd31 - rd_idx) : rd_idx;

   // R rounds chained combinationally; round j produces rk[cnt+j].
   assign k_chain[0] = k_q;
   for (genvar j = 0; j < R; j++) begin : g_round
      logic [31:0] ck_j;
      assign wr_idx[j] = cnt_q + 5'(j);
      assign ck_j      = ck_word(wr_idx[j]);
      sm4_keyexp_round u_round (
         .k_in  (k_chain[j]),
         .ck    (ck_j),
         .k_out (k_chain[j+1]),
         .rk    (rk_w[j])
      );
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      slot_d       = slot_q;
      done_d       = 1'b0;
      slot_valid_d = slot_valid_q;
      rd_data_d    = rd_data_q;
      rd_hit_d     = rd_hit_q;

      // Read sees storage and flags as they were before this edge.
      if (rd_en) begin
         rd_data_d = store_mem[rd_slot][rd_word];
         rd_hit_d  = slot_valid_q[rd_slot];
      end

      case (state_q)
         ST_IDLE: begin
            // abort is ignored while idle, so acceptance always wins here.
            if (key_valid) begin
               k_d                    = key_in ^ {FK0, FK1, FK2, FK3};
               slot_d                 = key_slot;
               slot_valid_d[key_slot] = 1'b0;
               cnt_d                  = '0;
               state_d                = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               k_d   = k_chain[R];
               cnt_d = cnt_q + CNT_STEP;   // wraps to 0 on the final step
               if (cnt_q == CNT_LAST) begin
                  state_d              = ST_IDLE;
                  done_d               = 1'b1;
                  slot_valid_d[slot_q] = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         slot_q       <= '0;
         done_q       <= 1'b0;
         slot_valid_q <= '0;
         rd_data_q    <= '0;
         rd_hit_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         slot_q       <= slot_d;
         done_q       <= done_d;
         slot_valid_q <= slot_valid_d;
         rd_data_q    <= rd_data_d;
         rd_hit_q     <= rd_hit_d;
      end
   end

   // Working key state carries no control meaning, so it is not reset.
   always_ff @(posedge clk) begin
      k_q <= k_d;
   end

`ifdef SM4_KEY_ZEROIZE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int w = 0; w < 32; w++) begin
               store_mem[s][w] <= '0;
            end
         end
      end else if (run && abort) begin
         for (int w = 0; w < 32; w++) begin
            store_mem[slot_q][w] <= '0;
         end
      end else if (run) begin
         for (int j = 0; j < R; j++) begin
            store_mem[slot_q][wr_idx[j]] <= rk_w[j];
         end
      end
   end
`else
   // No reset or clear: R plain write ports, suitable for distributed RAM.
   always_ff @(posedge clk) begin
      if (run && !abort) begin
         for (int j = 0; j < R; j++) begin
            store_mem[slot_q][wr_idx[j]] <= rk_w[j];
         end
      end
   end
`endif

endmodule

// File: tb/tb_sm4_key_schedule_mr.sv
module tb_sm4_key_schedule_mr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst [2];
   logic         key_valid [2];
   logic         key_ready [2];
   logic [127:0] key_in [2];
   logic [0:0]   key_slot [2];
   logic         abort [2];
   logic         busy [2];
   logic         done [2];
   logic [1:0]   slot_valid [2];
   logic         rd_en [2];
   logic [0:0]   rd_slot [2];
   logic [4:0]   rd_idx [2];
   logic         rd_dec [2];
   logic [31:0]  rd_data [2];
   logic         rd_hit [2];

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] KEY  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY3 = 128'hdeadbeef00112233445566778899aabb;

   sm4_key_schedule_mr #(.ROUNDS_PER_CYCLE(1), .NUM_SLOTS(2)) dut_r1 (
      .clk(clk), .rst(rst[0]), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
      .key_in(key_in[0]), .key_slot(key_slot[0]), .abort(abort[0]), .busy(busy[0]),
      .done(done[0]), .slot_valid(slot_valid[0]), .rd_en(rd_en[0]), .rd_slot(rd_slot[0]),
      .rd_idx(rd_idx[0]), .rd_dec(rd_dec[0]), .rd_data(rd_data[0]), .rd_hit(rd_hit[0])
   );

   sm4_key_schedule_mr #(.ROUNDS_PER_CYCLE(8), .NUM_SLOTS(2)) dut_r8 (
      .clk(clk), .rst(rst[1]), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
      .key_in(key_in[1]), .key_slot(key_slot[1]), .abort(abort[1]), .busy(busy[1]),
      .done(done[1]), .slot_valid(slot_valid[1]), .rd_en(rd_en[1]), .rd_slot(rd_slot[1]),
      .rd_idx(rd_idx[1]), .rd_dec(rd_dec[1]), .rd_data(rd_data[1]), .rd_hit(rd_hit[1])
   );

   // ---------------- reference key schedule ----------------
   localparam logic [127:0] SB_ROW [16] = '{
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sbox_b(input logic [7:0] x);
      logic [127:0] row;
      row = SB_ROW[x[7:4]];
      return row[8*(15 - int'(x[3:0])) +: 8];
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Returns rk[i] in bits [32*i +: 32].
   function automatic logic [1023:0] expand(input logic [127:0] mk);
      logic [31:0]   k [36];
      logic [31:0]   t, ckw;
      logic [1023:0] res;
      k[0] = mk[127:96] ^ 32'ha3b1bac6;
      k[1] = mk[95:64]  ^ 32'h56aa3350;
      k[2] = mk[63:32]  ^ 32'h677d9197;
      k[3] = mk[31:0]   ^ 32'hb27022dc;
      res = '0;
      for (int i = 0; i < 32; i++) begin
         ckw = '0;
         for (int j = 0; j < 4; j++) ckw = (ckw << 8) | 32'(((4 * i + j) * 7) % 256);
         t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ckw;
         t = {sbox_b(t[31:24]), sbox_b(t[23:16]), sbox_b(t[15:8]), sbox_b(t[7:0])};
         k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
         res[32*i +: 32] = k[i+4];
      end
      return res;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit            m_busy [2];
   bit            m_done [2];
   int            m_left [2];
   logic [0:0]    m_slot [2];
   logic [1023:0] m_pend [2];
   bit   [1:0]    m_valid [2];
   bit            m_known [2][2];
   logic [31:0]   m_store [2][2][32];
   logic [31:0]   m_rd_data [2];
   bit            m_rd_hit [2];
   bit            m_rd_chk [2];
   int            widx;

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst[u]) begin
            m_busy[u] = 0; m_done[u] = 0; m_valid[u] = '0;
            m_rd_data[u] = '0; m_rd_hit[u] = 0; m_rd_chk[u] = 1;
`ifdef SM4_KEY_ZEROIZE_EN
            for (int s = 0; s < 2; s++) begin
               for (int w = 0; w < 32; w++) m_store[u][s][w] = '0;
               m_known[u][s] = 1;
            end
`endif
         end else begin
            if (rd_en[u]) begin
               widx = rd_dec[u] ? 31 - int'(rd_idx[u]) : int'(rd_idx[u]);
               m_rd_hit[u]  = m_valid[u][rd_slot[u]];
               m_rd_chk[u]  = m_known[u][rd_slot[u]];
               m_rd_data[u] = m_store[u][rd_slot[u]][widx];
            end
            m_done[u] = 0;
            if (m_busy[u]) begin
               if (abort[u]) begin
                  m_busy[u] = 0;
`ifdef SM4_KEY_ZEROIZE_EN
                  for (int w = 0; w < 32; w++) m_store[u][m_slot[u]][w] = '0;
                  m_known[u][m_slot[u]] = 1;
`endif
               end else begin
                  m_left[u]--;
                  if (m_left[u] == 0) begin
                     m_busy[u] = 0;
                     m_done[u] = 1;
                     m_valid[u][m_slot[u]] = 1;
                     for (int w = 0; w < 32; w++) m_store[u][m_slot[u]][w] = m_pend[u][32*w +: 32];
                     m_known[u][m_slot[u]] = 1;
                  end
               end
            end else if (key_valid[u]) begin
               m_busy[u] = 1;
               m_left[u] = (u == 0) ? 32 : 4;
               m_slot[u] = key_slot[u];
               m_pend[u] = expand(key_in[u]);
               m_valid[u][key_slot[u]] = 0;
               m_known[u][key_slot[u]] = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d_key_ready", u), 128'(key_ready[u]), 128'(!m_busy[u]));
         chk($sformatf("u%0d_busy", u), 128'(busy[u]), 128'(m_busy[u]));
         chk($sformatf("u%0d_done", u), 128'(done[u]), 128'(m_done[u]));
         chk($sformatf("u%0d_slot_valid", u), 128'(slot_valid[u]), 128'(m_valid[u]));
         chk($sformatf("u%0d_rd_hit", u), 128'(rd_hit[u]), 128'(m_rd_hit[u]));
         if (m_rd_chk[u]) chk($sformatf("u%0d_rd_data", u), 128'(rd_data[u]), 128'(m_rd_data[u]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic accept(input int u, input logic [127:0] k, input logic s);
      @(negedge clk);
      key_valid[u] = 1'b1; key_in[u] = k; key_slot[u] = s;
      @(negedge clk);
      key_valid[u] = 1'b0;
   endtask

   task automatic wait_done(input int u, input int exp_n, input string nm);
      int n = 0;
      do begin
         @(posedge clk); n++; #1;
      end while (!done[u] && n < 200);
      chk(nm, 128'(n), 128'(exp_n));
   endtask

   task automatic rd(input int u, input logic s, input int idx, input logic dec);
      @(negedge clk);
      rd_en[u] = 1'b1; rd_slot[u] = s; rd_idx[u] = 5'(idx); rd_dec[u] = dec;
      @(posedge clk); #1;
      rd_en[u] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] ref_rk;
      int n, gap;
      bit seen;

      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b1; key_valid[u] = 1'b0; key_in[u] = '0; key_slot[u] = '0;
         abort[u] = 1'b0; rd_en[u] = 1'b0; rd_slot[u] = '0; rd_idx[u] = '0; rd_dec[u] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk("reset_key_ready", 128'(key_ready[0]), 128'(1));
      chk("reset_busy", 128'(busy[0]), 128'(0));
      chk("reset_slot_valid", 128'(slot_valid[1]), 128'(0));
      chk("reset_rd_data", 128'(rd_data[0]), 128'(0));

      // Pin the reference model to published SM4 values.
      ref_rk = expand(KEY);
      chk("model_rk0", 128'(ref_rk[31:0]), 128'(32'hf12186f9));
      chk("model_rk31", 128'(ref_rk[1023:992]), 128'(32'h9124a012));

      // Test 1: R=1 into slot 0
      accept(0, KEY, 1'b0);
      wait_done(0, 32, "t1_latency");
      chk("t1_slot_valid", 128'(slot_valid[0]), 128'(2'b01));
      rd(0, 1'b0, 0, 1'b0);
      chk("t1_rk0", 128'(rd_data[0]), 128'(32'hf12186f9));
      chk("t1_hit", 128'(rd_hit[0]), 128'(1));
      rd(0, 1'b0, 31, 1'b0);
      chk("t1_rk31", 128'(rd_data[0]), 128'(32'h9124a012));
      rd(0, 1'b0, 0, 1'b1);
      chk("t1_dec0", 128'(rd_data[0]), 128'(32'h9124a012));

      // Test 2: R=8, same key, full readback
      accept(1, KEY, 1'b0);
      wait_done(1, 4, "t2_latency");
      for (int i = 0; i < 32; i++) begin
         rd(1, 1'b0, i, 1'b0);
         if (i == 0)  chk("t2_rk0", 128'(rd_data[1]), 128'(32'hf12186f9));
         if (i == 31) chk("t2_rk31", 128'(rd_data[1]), 128'(32'h9124a012));
      end

      // Test 3: expand into slot 1 while alternately reading slots 0 and 1
      @(negedge clk);
      key_valid[0] = 1'b1; key_in[0] = KEY2; key_slot[0] = 1'b1;
      rd_en[0] = 1'b1; rd_slot[0] = 1'b0; rd_idx[0] = 5'd0; rd_dec[0] = 1'b0;
      n = 0; seen = 0;
      do begin
         @(posedge clk); n++; #1;
         key_valid[0] = 1'b0;
         if (rd_slot[0] == 1'b1 && rd_hit[0] && !done[0]) seen = 1;
         if (!done[0]) begin
            rd_slot[0] = 1'(n % 2); rd_idx[0] = 5'(n);
         end
      end while (!done[0] && n < 100);
      rd_en[0] = 1'b0;
      chk("t3_latency", 128'(n), 128'(33));
      chk("t3_slot1_hit_early", 128'(seen), 128'(0));
      rd(0, 1'b1, 7, 1'b1);
      chk("t3_slot1_hit", 128'(rd_hit[0]), 128'(1));

      // Test 4: abort on the 10th RUN cycle, slot 1
      accept(0, KEY3, 1'b1);
      repeat (9) @(negedge clk);
      abort[0] = 1'b1;
      @(posedge clk); #1;
      chk("t4_key_ready", 128'(key_ready[0]), 128'(1));
      chk("t4_no_done", 128'(done[0]), 128'(0));
      chk("t4_slot1_invalid", 128'(slot_valid[0][1]), 128'(0));
      @(negedge clk);
      abort[0] = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd(0, 1'b1, i, 1'b0);
         chk("t4_abort_hit", 128'(rd_hit[0]), 128'(0));
`ifdef SM4_KEY_ZEROIZE_EN
         chk("t4_zeroized", 128'(rd_data[0]), 128'(0));
`endif
      end
      accept(0, KEY, 1'b1);
      wait_done(0, 32, "t4_relatency");
      rd(0, 1'b1, 31, 1'b1);
      chk("t4_new_rk0", 128'(rd_data[0]), 128'(32'hf12186f9));
      // abort coinciding with acceptance while idle: acceptance wins
      @(negedge clk);
      key_valid[1] = 1'b1; abort[1] = 1'b1; key_in[1] = KEY2; key_slot[1] = 1'b1;
      @(negedge clk);
      key_valid[1] = 1'b0; abort[1] = 1'b0;
      chk("t4_idle_abort_busy", 128'(busy[1]), 128'(1));
      wait_done(1, 4, "t4_idle_abort_latency");

      // Test 5: key_valid held high, alternating slots
      @(negedge clk);
      key_valid[1] = 1'b1; key_in[1] = KEY ^ 128'(1); key_slot[1] = 1'b0;
      for (int a = 0; a < 6; a++) begin
         @(negedge clk);
         key_in[1] = KEY ^ 128'(a + 2); key_slot[1] = 1'((a + 1) % 2);
         gap = 0;
         while (!key_ready[1] && gap < 50) begin
            @(negedge clk); gap++;
         end
         chk("t5_gap", 128'(gap), 128'(4));
         chk("t5_done_at_accept", 128'(done[1]), 128'(1));
      end
      key_valid[1] = 1'b0;
      @(negedge clk);
      chk("t5_both_valid", 128'(slot_valid[1]), 128'(2'b11));
      rd(1, 1'b0, 3, 1'b0);
      rd(1, 1'b1, 17, 1'b1);
      // reset in the middle of an expansion
      accept(1, KEY3, 1'b0);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("t5_rst_key_ready", 128'(key_ready[1]), 128'(1));
      chk("t5_rst_slot_valid", 128'(slot_valid[1]), 128'(0));
      rd(1, 1'b1, 0, 1'b0);
      chk("t5_rst_hit", 128'(rd_hit[1]), 128'(0));
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
